sevenseg_bcd_driver: RTL and testbench
======================================

// Module: sevenseg_bcd_driver
// PURPOSE
//   Parametrised N-digit seven-segment driver. Accepts an unsigned binary value via a
//   load/ready handshake, saturates it to the largest value the digits can show,
//   converts it to BCD with a sequential double-dabble engine (one bit per cycle) and
//   drives static per-digit segment outputs. Sits between the application's counters
//   and the board's seven-segment pins; the display holds the last converted value.
// PARAMETERS
//   VALUE_W     8   width of the binary input value (>= 4)
//   DIGITS      2   number of decimal digits driven (1..5)
//   ACTIVE_LOW  1   1: segment lit when output is 0; 0: lit when output is 1
//   BLANK_LZ    1   1: blank leading zero digits (units digit never blanked)
// PORTS
//   clk        in   1            system clock, all logic on rising edge
//   rst        in   1            synchronous, active-high reset
//   value      in   VALUE_W      unsigned binary value to display
//   load       in   1            request to convert value; accepted when load && ready
//   ready      out  1            high when idle and able to accept load
//   done       out  1            one-cycle pulse when the display updates
//   overflow   out  1            last accepted value exceeded MAXV and was saturated
//   seg        out  7*DIGITS     digit k at [7k+6:7k], order {g,f,e,d,c,b,a}; k=0 units
// BEHAVIOUR
//   - MAXV = 10**DIGITS - 1 (localparam). Capture: v = (value > MAXV) ? MAXV : value;
//     overflow <= (value > MAXV), updated only on acceptance.
//   - FSM IDLE -> CONVERT -> UPDATE -> IDLE.
//     IDLE: ready=1. load=1 captures v into shift reg {bcd[4*DIGITS-1:0], bin[VALUE_W-1:0]},
//       bcd cleared, bit counter = VALUE_W, go CONVERT.
//     CONVERT: ready=0. Each cycle: add 3 to every BCD nibble >= 5, then shift left 1;
//       decrement counter; after VALUE_W shifts go UPDATE.
//     UPDATE: ready=0; digit register <= bcd; done=1 this cycle only; go IDLE.
//   - Latency: load accepted at edge 0 -> seg reflects new value and done=1 after edge
//     VALUE_W+1; ready high again the following cycle. Throughput one value per VALUE_W+2.
//   - load while ready=0 is ignored (no queueing); value need only be valid on acceptance.
//   - seg is combinational from the digit register only; never shows partial results.
//   - Leading-zero blanking (BLANK_LZ=1): digit k>0 blank iff it and all higher digits
//     are 0. Blank = all segments unlit. Value 0 shows a single "0".
//   - Polarity: encoder yields active-high pattern; ACTIVE_LOW inverts all outputs.
//   - Segment patterns {g..a}: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110
//     5=1101101 6=1111101 7=0000111 8=1111111 9=1101111; nibble > 9 -> blank.
//   - Reset (any state, incl. mid-conversion): state IDLE, ready=1, done=0, overflow=0,
//     digit register 0 (display "0" with blanking, else all "0"); conversion aborted.
//   - Width: BCD register 4*DIGITS bits; saturation guarantees no BCD overflow.
// STRUCTURE
//   - Shared package: segment pattern constants for 0-9, BLANK pattern, FSM state enum.
//   - Sub-module sevenseg_encode: combinational 4-bit digit + blank flag -> 7-bit
//     active-high segments; instantiated DIGITS times via generate.
//   - Top holds FSM, double-dabble shift register, counter, digit register, LZ logic.
// TESTING (defaults unless stated; seg shown active-low, tens then units)
//   - Reset, then idle: seg = 7'h7F (blank), 7'h40 ("0"); ready=1, done=0, overflow=0.
//   - load value=42 one cycle -> ready=0 for 9 cycles, done pulse at edge 9,
//     seg = 7'h19 ("4"), 7'h24 ("2"); overflow=0.
//   - load value=150 -> display "99", overflow=1; then load 5 -> tens blank, units
//     7'h12 ("5"), overflow=0; with BLANK_LZ=0 tens shows 7'h40 ("0").
//   - load 42 then load 77 pulsed 3 cycles later (busy) -> 77 ignored, display "42".
//   - load 42, assert rst at 4th CONVERT cycle -> done never pulses, display "0",
//     ready=1 the cycle after rst deasserts.
//   - VALUE_W=10, DIGITS=3, ACTIVE_LOW=0: load 1023 -> "999", overflow=1, done after
//     11 cycles; load 305 -> 7'h4F,7'h3F,7'h6D.

Source files
------------

// File: rtl/sevenseg_bcd_driver_pkg.sv
// Shared definitions for the seven-segment BCD driver: segment patterns and FSM states.
package sevenseg_bcd_driver_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_bcd_driver_encode.sv
// One BCD digit plus blank flag to an active-high seven-segment pattern.
module sevenseg_encode
  import sevenseg_bcd_driver_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg_pattern(digit);
  end

endmodule

// File: rtl/sevenseg_bcd_driver.sv
// N-digit seven-segment driver: saturate, sequential double-dabble to BCD, static segments.
module sevenseg_bcd_driver
  import sevenseg_bcd_driver_pkg::*;
#(
  parameter int VALUE_W    = 8,
  parameter int DIGITS     = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int MAXV  = 10**DIGITS - 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CMP_W = (VALUE_W > 20) ? VALUE_W : 20;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  state_t              state;
  logic [BCD_W-1:0]    bcd;
  logic [VALUE_W-1:0]  bin;
  logic [CNT_W-1:0]    cnt;
  logic [BCD_W-1:0]    digits;
  logic                cap_ovf;
  logic [VALUE_W-1:0]  v_sat;
  logic [DIGITS-1:0]   blank;
  logic                zero_above;
  logic [7*DIGITS-1:0] seg_hi;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Saturation keeps the BCD register from ever needing an extra digit
  always_comb begin
    cap_ovf = (CMP_W'(value) > CMP_W'(MAXV));
    v_sat   = cap_ovf ? VALUE_W'(MAXV) : value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
      digits   <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bcd      <= '0;
            bin      <= v_sat;
            overflow <= cap_ovf;
            cnt      <= CNT_W'(VALUE_W);
            ready    <= 1'b0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {dabble_adjust(bcd), bin} << 1;
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= UPDATE;
        end
        UPDATE: begin
          digits <= bcd;
          done   <= 1'b1;
          ready  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A digit above the units is blank when it and everything above it is zero
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (digits[4*k +: 4] == 4'd0);
      blank[k]   = (BLANK_LZ != 0) && (k != 0) && zero_above;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    sevenseg_encode u_enc (
      .digit (digits[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg_hi[7*g +: 7])
    );
  end

  assign seg = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;

endmodule

// File: tb/tb_sevenseg_bcd_driver.sv
// Directed bench for sevenseg_bcd_driver: default, no-blanking, and 10-bit/3-digit active-high builds.
module tb_sevenseg_bcd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  value;
  logic        load;
  logic        ready_a, done_a, ovf_a;
  logic [13:0] seg_a;
  logic        ready_b, done_b, ovf_b;
  logic [13:0] seg_b;
  logic [9:0]  value_c;
  logic        load_c;
  logic        ready_c, done_c, ovf_c;
  logic [20:0] seg_c;

  int vectors    = 0;
  int miscompares = 0;
  int cycles;
  int pulses;

  always #5 clk = ~clk;

  sevenseg_bcd_driver #(.VALUE_W(8), .DIGITS(2), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .ready(ready_a), .done(done_a), .overflow(ovf_a), .seg(seg_a));

  sevenseg_bcd_driver #(.VALUE_W(8), .DIGITS(2), .ACTIVE_LOW(1), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .ready(ready_b), .done(done_b), .overflow(ovf_b), .seg(seg_b));

  sevenseg_bcd_driver #(.VALUE_W(10), .DIGITS(3), .ACTIVE_LOW(0), .BLANK_LZ(1)) u_c (
    .clk(clk), .rst(rst), .value(value_c), .load(load_c),
    .ready(ready_c), .done(done_c), .overflow(ovf_c), .seg(seg_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done on the selected instance (0: a, 1: c); cycles counts edges since acceptance
  task automatic wait_done(input bit sel_c, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sel_c ? done_c : done_a) && n < 40);
    check("done_timeout", sel_c ? done_c : done_a, 1'b1);
  endtask

  task automatic load_a(input logic [7:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    value = 8'hxx;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; load_c = 1'b0; value_c = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_seg_a", seg_a, {7'h7F, 7'h40});
    check("reset_seg_b", seg_b, {7'h40, 7'h40});
    check("reset_seg_c", seg_c, {7'h00, 7'h00, 7'h3F});
    check("reset_ready", ready_a, 1'b1);
    check("reset_done", done_a, 1'b0);
    check("reset_ovf", ovf_a, 1'b0);

    // 42: exact latency and ready profile
    load_a(8'd42);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      if (ready_a !== 1'b0 || done_a !== 1'b0) pulses++;
      if (i < 8) tick();
    end
    check("busy_window_42", pulses, 0);
    tick();
    check("done_edge9_42", done_a, 1'b1);
    check("ready_back_42", ready_a, 1'b1);
    check("seg_42", seg_a, {7'h19, 7'h24});
    check("ovf_42", ovf_a, 1'b0);
    tick();
    check("done_single_42", done_a, 1'b0);

    // Saturation
    load_a(8'd150);
    wait_done(1'b0, cycles);
    check("seg_150", seg_a, {7'h10, 7'h10});
    check("ovf_150", ovf_a, 1'b1);

    // Leading-zero blanking on vs off
    tick();
    load_a(8'd5);
    wait_done(1'b0, cycles);
    check("seg_5_blank", seg_a, {7'h7F, 7'h12});
    check("seg_5_noblank", seg_b, {7'h40, 7'h12});
    check("ovf_5", ovf_a, 1'b0);

    // Load while busy is ignored
    tick();
    load_a(8'd42);
    tick(); tick();
    load_a(8'd77);
    wait_done(1'b0, cycles);
    check("seg_42_busy", seg_a, {7'h19, 7'h24});
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done_a === 1'b1) pulses++;
    end
    check("no_second_conv", pulses, 0);
    check("seg_42_hold", seg_a, {7'h19, 7'h24});

    // Reset during conversion
    load_a(8'd150);
    wait_done(1'b0, cycles);
    tick();
    load_a(8'd42);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_ready", ready_a, 1'b1);
    check("rst_mid_seg", seg_a, {7'h7F, 7'h40});
    check("rst_mid_ovf", ovf_a, 1'b0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (done_a === 1'b1) pulses++;
      tick();
    end
    check("rst_mid_no_done", pulses, 0);
    check("rst_mid_seg_hold", seg_a, {7'h7F, 7'h40});

    // Wide, active-high build
    value_c = 10'd1023;
    load_c  = 1'b1;
    tick();
    load_c  = 1'b0;
    wait_done(1'b1, cycles);
    check("latency_1023", cycles, 11);
    check("seg_1023", seg_c, {7'h6F, 7'h6F, 7'h6F});
    check("ovf_1023", ovf_c, 1'b1);
    tick();
    value_c = 10'd305;
    load_c  = 1'b1;
    tick();
    load_c  = 1'b0;
    wait_done(1'b1, cycles);
    check("seg_305", seg_c, {7'h4F, 7'h3F, 7'h6D});
    check("ovf_305", ovf_c, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
